// File: rtl/icache_refill_if.sv
// Fetch-side, memory-side and data-array-write signals of the I-cache refill controller.
// master = the controller; slave = the fetch stage, memory and data array around it.
// Ports: cpu_req/cpu_addr/flush in, cpu_hit/mem_stall out, mem_req/mem_addr out, mem_ack/mem_rdata in, dwr_* out.
interface icache_refill_if #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
);
  localparam int WB = $clog2(LINE_WORDS);

  logic                  cpu_req;
  logic [ADDR_W-1:0]     cpu_addr;
  logic                  flush;
  logic                  cpu_hit;
  logic                  mem_stall;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;
  logic                  dwr_en;
  logic [INDEX_BITS-1:0] dwr_index;
  logic [WB-1:0]         dwr_word;
  logic [31:0]           dwr_data;

  modport master (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    output cpu_hit, mem_stall, mem_req, mem_addr,
           dwr_en, dwr_index, dwr_word, dwr_data
  );

  modport slave (
    output cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    input  cpu_hit, mem_stall, mem_req, mem_addr,
           dwr_en, dwr_index, dwr_word, dwr_data
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Miss/refill controller for a direct-mapped I-cache: owns tag/valid arrays, refills lines beat by beat.
// Latency: hit lookup combinational; zero-wait miss stalls LINE_WORDS+2 cycles; flush takes 2**INDEX_BITS cycles.
// Backpressure: each beat waits for mem_ack with mem_req/mem_addr held; mem_stall freezes fetch meanwhile.
// Ports: clk, rst (sync, active-high), bus (icache_refill_if.master).
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  icache_refill_if.master bus
);
  localparam int WB    = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - 2 - WB - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  localparam logic [WB-1:0]         LAST_BEAT = WB'(LINE_WORDS - 1);
  localparam logic [INDEX_BITS-1:0] LAST_LINE = INDEX_BITS'(LINES - 1);

  typedef enum logic [1:0] {IDLE, REFILL, UPDATE, FLUSH} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_arr [LINES];
  logic [INDEX_BITS-1:0] line_index;
  logic [TAG_W-1:0]      line_tag;
  logic [WB-1:0]         beat;
  logic [INDEX_BITS-1:0] flush_ctr;
  logic                  pending_flush;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  lookup_hit;

  // Byte offset and word-in-line bits play no part in the lookup.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^bus.cpu_addr[1+WB:0];

  assign req_index  = bus.cpu_addr[2+WB +: INDEX_BITS];
  assign req_tag    = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign lookup_hit = valid[req_index] && (tag_arr[req_index] == req_tag);

  // Lookup result only means anything while the arrays are stable, i.e. in IDLE.
  assign bus.cpu_hit = (state == IDLE) && lookup_hit;

  // A flush in IDLE is not a miss: the fetch stalls only once FLUSH starts.
  always_comb begin
    bus.mem_stall = 1'b1;
    if (state == IDLE)
      bus.mem_stall = bus.cpu_req && !lookup_hit && !bus.flush;
  end

  // mem_addr is built purely from latched line base and beat, so it cannot move while waiting for ack.
  assign bus.mem_req   = (state == REFILL);
  assign bus.mem_addr  = {line_tag, line_index, beat, 2'b00};
  assign bus.dwr_en    = (state == REFILL) && bus.mem_ack;
  assign bus.dwr_index = line_index;
  assign bus.dwr_word  = beat;
  assign bus.dwr_data  = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      beat          <= '0;
      pending_flush <= 1'b0;
      flush_ctr     <= '0;
      line_index    <= '0;
      line_tag      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            flush_ctr <= '0;
            state     <= FLUSH;
          end else if (bus.cpu_req && !lookup_hit) begin
            line_index <= req_index;
            line_tag   <= req_tag;
            beat       <= '0;
            state      <= REFILL;
          end
        end

        REFILL: begin
          if (bus.flush)
            pending_flush <= 1'b1;
          if (bus.mem_ack) begin
            beat <= beat + WB'(1);
            if (beat == LAST_BEAT)
              state <= UPDATE;
          end
        end

        UPDATE: begin
          tag_arr[line_index] <= line_tag;
          valid[line_index]   <= 1'b1;
          // A flush arriving in this very cycle is honoured immediately rather than lost.
          if (pending_flush || bus.flush) begin
            flush_ctr <= '0;
            state     <= FLUSH;
          end else begin
            state <= IDLE;
          end
        end

        FLUSH: begin
          valid[flush_ctr] <= 1'b0;
          flush_ctr        <= flush_ctr + INDEX_BITS'(1);
          if (flush_ctr == LAST_LINE) begin
            pending_flush <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomised self-checking bench for icache_refill_ctrl against a line-level cache model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Ports: drives every signal of icache_refill_if from the slave side.
module tb_icache_refill_ctrl;
  localparam int LW    = 4;
  localparam int IB    = 6;
  localparam int AW    = 32;
  localparam int LINES = 1 << IB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  icache_refill_if #(.LINE_WORDS(LW), .INDEX_BITS(IB), .ADDR_W(AW)) bus ();

  icache_refill_ctrl #(.LINE_WORDS(LW), .INDEX_BITS(IB), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Cache contents model: which lines are present and with which tag.
  bit          mv [LINES];
  int unsigned mt [LINES];

  int n_vec = 0;
  int n_err = 0;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 4) & (LINES - 1);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a >> (4 + IB);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch of address a. On a miss every beat waits wmin..wmax cycles for ack;
  // flush_beat >= 0 pulses flush in the first cycle of that beat.
  task automatic fetch(input logic [31:0] a, input int wmin, input int wmax, input int flush_beat);
    bit exp_hit;
    int stalls, exp_stalls, n_dwr, w;
    logic [31:0] d;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    bus.flush    = 1'b0;
    bus.mem_ack  = 1'b0;
    exp_hit      = model_hit(a);
    @(negedge clk);
    chk_eq("lookup_hit", bus.cpu_hit, exp_hit);
    chk_eq("lookup_stall", bus.mem_stall, !exp_hit);
    chk_eq("lookup_req", bus.mem_req, 1'b0);
    if (exp_hit) begin
      chk_eq("hit_dwr_en", bus.dwr_en, 1'b0);
      bus.cpu_req = 1'b0;
      step();
      return;
    end
    stalls     = (bus.mem_stall === 1'b1) ? 1 : 0;
    exp_stalls = 2 + ((flush_beat >= 0) ? LINES : 0);
    n_dwr      = 0;
    step();
    for (int b = 0; b < LW; b++) begin
      w = $urandom_range(wmax, wmin);
      exp_stalls += w + 1;
      for (int k = 0; k <= w; k++) begin
        // Fetch-side inputs are scrambled: they must be ignored while refilling.
        bus.cpu_req   = 1'($urandom);
        bus.cpu_addr  = $urandom;
        bus.flush     = (b == flush_beat) && (k == 0);
        bus.mem_ack   = (k == w);
        d             = $urandom;
        bus.mem_rdata = d;
        @(negedge clk);
        if (bus.mem_stall === 1'b1) stalls++;
        if (bus.dwr_en === 1'b1) n_dwr++;
        chk_eq("refill_req", bus.mem_req, 1'b1);
        chk_eq("refill_addr", bus.mem_addr, (a & ~32'hF) | (b << 2));
        chk_eq("refill_hit", bus.cpu_hit, 1'b0);
        chk_eq("refill_dwr_en", bus.dwr_en, k == w);
        if (k == w) begin
          chk_eq("dwr_index", bus.dwr_index, idx_of(a));
          chk_eq("dwr_word", bus.dwr_word, b);
          chk_eq("dwr_data", bus.dwr_data, d);
        end
        step();
      end
    end
    // Line install cycle; a stray ack here must not write anything.
    bus.flush   = 1'b0;
    bus.mem_ack = 1'($urandom);
    @(negedge clk);
    if (bus.mem_stall === 1'b1) stalls++;
    chk_eq("update_req", bus.mem_req, 1'b0);
    chk_eq("update_dwr_en", bus.dwr_en, 1'b0);
    mv[idx_of(a)] = 1'b1;
    mt[idx_of(a)] = tag_of(a);
    step();
    if (flush_beat >= 0) begin
      for (int i = 0; i < LINES; i++) begin
        bus.mem_ack = 1'b0;
        @(negedge clk);
        if (bus.mem_stall === 1'b1) stalls++;
        if (i == 0 || i == LINES - 1) chk_eq("pflush_req", bus.mem_req, 1'b0);
        step();
      end
      model_clear();
    end
    chk_eq("dwr_pulses", n_dwr, LW);
    chk_eq("stall_cycles", stalls, exp_stalls);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    bus.mem_ack  = 1'b0;
    @(negedge clk);
    chk_eq("refetch_hit", bus.cpu_hit, model_hit(a));
    chk_eq("refetch_stall", bus.mem_stall, !model_hit(a));
    bus.cpu_req = 1'b0;
    step();
  endtask

  // Flush issued from IDLE, optionally together with a missing fetch; a second pulse mid-flush is absorbed.
  task automatic idle_flush(input bit with_miss);
    bus.cpu_req  = with_miss;
    bus.cpu_addr = 32'hFFFF_FFF0;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk_eq("iflush_stall", bus.mem_stall, 1'b0);
    chk_eq("iflush_req", bus.mem_req, 1'b0);
    step();
    bus.cpu_req = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      bus.flush = (i == 10);
      @(negedge clk);
      if (i == 0 || i == 10 || i == LINES - 1) begin
        chk_eq("flush_stall", bus.mem_stall, 1'b1);
        chk_eq("flush_req", bus.mem_req, 1'b0);
      end
      step();
    end
    bus.flush = 1'b0;
    model_clear();
    @(negedge clk);
    chk_eq("flush_done_stall", bus.mem_stall, 1'b0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected it to have finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int fb;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = 32'h0000_0100;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    model_clear();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk_eq("rst_req", bus.mem_req, 1'b0);
    chk_eq("rst_stall", bus.mem_stall, 1'b0);
    chk_eq("rst_dwr_en", bus.dwr_en, 1'b0);
    chk_eq("rst_hit", bus.cpu_hit, 1'b0);
    rst = 1'b0;
    step();

    // Zero-wait refill, then a hit in the same line, then 3-cycle-wait refill.
    fetch(32'h0000_0100, 0, 0, -1);
    fetch(32'h0000_0104, 0, 0, -1);
    fetch(32'h0000_0200, 3, 3, -1);
    // Same index, different tag: replaces the line, so the old address misses again.
    fetch(32'h0000_1100, 1, 1, -1);
    fetch(32'h0000_0100, 0, 1, -1);
    // Flush pending from beat 2, then everything misses.
    fetch(32'h0000_0300, 0, 0, 2);
    fetch(32'h0000_0200, 0, 0, -1);
    fetch(32'h0000_0100, 0, 0, -1);
    idle_flush(1'b1);
    fetch(32'h0000_0100, 0, 0, -1);

    // Synchronous reset during beat 1 of a refill.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0400;
    step();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    chk_eq("rst_mid_addr", bus.mem_addr, 32'h0000_0404);
    step();
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    model_clear();
    @(negedge clk);
    chk_eq("rst_mid_req", bus.mem_req, 1'b0);
    chk_eq("rst_mid_stall", bus.mem_stall, 1'b0);
    chk_eq("rst_mid_dwr_en", bus.dwr_en, 1'b0);
    step();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0100;
    @(negedge clk);
    chk_eq("rst_mid_lost_hit", bus.cpu_hit, 1'b0);
    chk_eq("rst_mid_lost_stall", bus.mem_stall, 1'b1);
    bus.cpu_req = 1'b0;
    step();

    // Random fetches over a small address pool so hits, conflicts and flushes all occur.
    for (int it = 0; it < 60; it++) begin
      a = ($urandom_range(3, 0) << 10) | ($urandom_range(7, 0) << 4) | ($urandom_range(3, 0) << 2);
      if ($urandom_range(15, 0) == 0) begin
        idle_flush(1'($urandom));
      end else begin
        fb = ($urandom_range(7, 0) == 0) ? int'($urandom_range(LW - 1, 0)) : -1;
        fetch(a, 0, 2, fb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
